// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with registered read data, handshake and occupancy flags.
// Define FIFO_ASSERTIONS_EN to compile the embedded SVA checks and cover points.
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_go;
    logic                  rd_go;

    // A write into a full FIFO is refused even when a read frees a slot in the same cycle.
    assign wr_go = wr_en && !full;
    assign rd_go = rd_en && !empty;

    assign full        = (count == DEPTH_CNT);
    assign almostfull  = (count == DEPTH_CNT - 1'b1);
    assign empty       = (count == '0);
    assign almostempty = (count == CNT_W'(1));

    // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_go;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;

            if (wr_go) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_go) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end

            case ({wr_go, rd_go})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ASSERTIONS_EN
    a_reset_vals: assert property (@(posedge clk)
        rst |-> (count == '0 && wr_ptr == '0 && rd_ptr == '0 && data_out == '0 &&
                 !wr_ack && !overflow && !underflow))
        else $error("sync_fifo: state not cleared by reset");

    a_wr_ack: assert property (@(posedge clk) disable iff (rst)
        wr_go |=> (wr_ack && !overflow))
        else $error("sync_fifo: accepted write without wr_ack");

    a_overflow: assert property (@(posedge clk) disable iff (rst)
        (wr_en && full) |=> (overflow && !wr_ack))
        else $error("sync_fifo: write into full FIFO not flagged");

    a_no_write: assert property (@(posedge clk) disable iff (rst)
        !wr_en |=> (!wr_ack && !overflow))
        else $error("sync_fifo: write status set without write request");

    a_underflow: assert property (@(posedge clk) disable iff (rst)
        (rd_en && empty) |=> (underflow && $stable(data_out)))
        else $error("sync_fifo: read from empty FIFO not flagged");

    a_no_read: assert property (@(posedge clk) disable iff (rst)
        !rd_en |=> (!underflow && $stable(data_out)))
        else $error("sync_fifo: read status or data changed without read request");

    a_read_ok: assert property (@(posedge clk) disable iff (rst)
        rd_go |=> !underflow)
        else $error("sync_fifo: accepted read flagged as underflow");

    a_flags: assert property (@(posedge clk) disable iff (rst)
        (full == (count == DEPTH_CNT)) && (empty == (count == '0)) &&
        (almostfull == (count == DEPTH_CNT - 1'b1)) && (almostempty == (count == CNT_W'(1))))
        else $error("sync_fifo: flags inconsistent with count");

    a_wr_wrap: assert property (@(posedge clk) disable iff (rst)
        (wr_go && wr_ptr == LAST_PTR) |=> (wr_ptr == '0))
        else $error("sync_fifo: write pointer failed to wrap");

    a_rd_wrap: assert property (@(posedge clk) disable iff (rst)
        (rd_go && rd_ptr == LAST_PTR) |=> (rd_ptr == '0))
        else $error("sync_fifo: read pointer failed to wrap");

    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count <= DEPTH_CNT)
        else $error("sync_fifo: count exceeds depth");

    a_full_both: assert property (@(posedge clk) disable iff (rst)
        (full && wr_en && rd_en) |=> (count == $past(count) - 1'b1))
        else $error("sync_fifo: full with read and write did not decrement");

    c_full:      cover property (@(posedge clk) disable iff (rst) full);
    c_overflow:  cover property (@(posedge clk) disable iff (rst) overflow);
    c_underflow: cover property (@(posedge clk) disable iff (rst) underflow);
    c_wr_wrap:   cover property (@(posedge clk) disable iff (rst) wr_go && wr_ptr == LAST_PTR);
    c_full_both: cover property (@(posedge clk) disable iff (rst) full && wr_en && rd_en);
`else
    // Checks excluded from this build.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: hand-built fill/drain table, corner sequences and
// a queue-based reference model that scores every output on every cycle.
module tb_sync_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, read data awaiting output, expected status.
    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout;
    logic         exp_ack, exp_ovf, exp_udf;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic         ack;
        logic         ovf;
        logic         udf;
        logic [3:0]   flags;   // {full, almostfull, empty, almostempty}
        logic [W-1:0] dout;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        exp_dout = '0;
        exp_ack  = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        int cnt;
        cnt = model_q.size();
        check({tag, ".wr_ack"},      wr_ack,      exp_ack);
        check({tag, ".overflow"},    overflow,    exp_ovf);
        check({tag, ".underflow"},   underflow,   exp_udf);
        check({tag, ".data_out"},    data_out,    exp_dout);
        check({tag, ".full"},        full,        cnt == DEPTH);
        check({tag, ".almostfull"},  almostfull,  cnt == DEPTH - 1);
        check({tag, ".empty"},       empty,       cnt == 0);
        check({tag, ".almostempty"}, almostempty, cnt == 1);
    endtask

    // One clock: drive at negedge, predict, clock, compare at next negedge.
    task automatic step(input logic wr, input logic rd, input logic [W-1:0] din, input string tag);
        logic acc_wr, acc_rd;
        int   cnt;
        cnt     = model_q.size();
        acc_wr  = wr && (cnt != DEPTH);
        acc_rd  = rd && (cnt != 0);
        exp_ack = acc_wr;
        exp_ovf = wr && !acc_wr;
        exp_udf = rd && !acc_rd;
        if (acc_rd) exp_q.push_back(model_q.pop_front());
        if (acc_wr) model_q.push_back(din);
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Fill 0x0001..0x0008 then one rejected write; drain eight then one rejected read.
        vecs[0]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000};
        vecs[4]  = '{1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 4'b0100, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 4'b1000, 16'h0000};
        vecs[8]  = '{1'b1, 1'b0, 16'h0009, 1'b0, 1'b1, 1'b0, 4'b1000, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0100, 16'h0001};
        vecs[10] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0002};
        vecs[11] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0003};
        vecs[12] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0004};
        vecs[13] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0005};
        vecs[14] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'h0006};
        vecs[15] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0001, 16'h0007};
        vecs[16] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0010, 16'h0008};
        vecs[17] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0010, 16'h0008};

        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.ack", i),   wr_ack,    vecs[i].ack);
            check($sformatf("tbl%0d.ovf", i),   overflow,  vecs[i].ovf);
            check($sformatf("tbl%0d.udf", i),   underflow, vecs[i].udf);
            check($sformatf("tbl%0d.flags", i), {full, almostfull, empty, almostempty}, vecs[i].flags);
            check($sformatf("tbl%0d.dout", i),  data_out,  vecs[i].dout);
        end

        // Pointer wrap: 5 in/out, then 8 in/out crossing the end of storage.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'hB000 + 16'(i), "wrap_w5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0000, "wrap_r5");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i), "wrap_w8");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 16'h0000, "wrap_r8");
            check("wrap_order", data_out, 16'hA000 + 16'(i));
        end

        // Simultaneous read and write at full, empty and mid occupancy.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'hC000 + 16'(i), "sim_fill");
        step(1'b1, 1'b1, 16'hDEAD, "sim_full");
        check("sim_full.overflow", overflow, 1'b1);
        check("sim_full.count7",   almostfull, 1'b1);
        check("sim_full.dout",     data_out, 16'hC000);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'h0000, "sim_drain");
        step(1'b1, 1'b1, 16'h5A5A, "sim_empty");
        check("sim_empty.underflow", underflow, 1'b1);
        check("sim_empty.count1",    almostempty, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h1100 + 16'(i), "sim_to4");
        step(1'b1, 1'b1, 16'h2222, "sim_mid");
        check("sim_mid.flags", {full, almostfull, empty, almostempty}, 4'b0000);
        check("sim_mid.ack",   wr_ack, 1'b1);
        check("sim_mid.dout",  data_out, 16'h5A5A);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0000, "sim_drain4");

        // Asynchronous reset with three entries held and non-zero read data.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h3300 + 16'(i), "rst_fill");
        step(1'b0, 1'b1, 16'h0000, "rst_rd");
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 16'h0000, "post_rst_rd");
        check("post_rst.underflow", underflow, 1'b1);

        // Random traffic: write-biased half, then read-biased half.
        for (int i = 0; i < 1000; i++) begin
            logic wr, rd;
            if (i < 500) begin
                wr = ($urandom_range(0, 99) < 70);
                rd = ($urandom_range(0, 99) < 40);
            end else begin
                wr = ($urandom_range(0, 99) < 40);
                rd = ($urandom_range(0, 99) < 70);
            end
            step(wr, rd, 16'($urandom), "rand");
        end

        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
